// File: rtl/conv_sequencer_pkg.sv
// Shared types and geometry for the 3x3-over-4x4 convolution sequencer.
// Sequencer state enum plus tap-to-image offset helper.
package conv_sequencer_pkg;

  localparam int IMG_DIM = 4;
  localparam int K_DIM   = 3;
  localparam int OUT_DIM = 2;
  localparam int TAPS    = K_DIM * K_DIM;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_MEM,
    RUN,
    OUT,
    FIN
  } state_t;

  // ky*IMG_DIM + kx == t + ky, since t = ky*K_DIM + kx
  function automatic logic [3:0] tap_off(
    input logic [3:0] t
  );
    logic [3:0] ky;
    ky = (t >= 4'(2 * K_DIM)) ? 4'd2 :
         (t >= 4'(K_DIM))     ? 4'd1 : 4'd0;
    return t + ky;
  endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// Operand fetch and result handshake bundle of conv_sequencer.
// master = sequencer, slave = operand store / result consumer.
interface conv_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
);

  logic        [3:0]        in_idx;
  logic        [3:0]        f_idx;
  logic signed [DATA_W-1:0] pix;
  logic signed [DATA_W-1:0] coef;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic        [1:0]        out_pos;

  modport master (
    output in_idx,
    output f_idx,
    input  pix,
    input  coef,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_pos
  );

  modport slave (
    input  in_idx,
    input  f_idx,
    output pix,
    output coef,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_pos
  );

endinterface

// File: rtl/conv_mac.sv
// Signed multiply-accumulate; sum is this tap's result, acc holds it.
// load restarts the sum with the current product.
module conv_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     load,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  sum
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_x;
  logic signed [ACC_W-1:0]    acc;

  assign prod   = a * b;
  assign prod_x = ACC_W'(prod);
  assign sum    = load ? prod_x : acc + prod_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// 3x3 kernel over 4x4 image, four results with valid/ready handshake.
// Define CONV_SEQUENCER_RELU_EN to clamp negative results to zero.
module conv_sequencer
  import conv_sequencer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic mem_done,
  input  logic abort,
  output logic busy,
  output logic done,
  conv_sequencer_if.master bus
);

  state_t                  state;
  logic        [3:0]       tap;
  logic        [1:0]       pos;
  logic        [3:0]       base;
  logic                    run;
  logic                    last_tap;
  logic                    last_pos;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] res;

  assign run      = state == RUN;
  assign last_tap = tap == 4'(TAPS - 1);
  assign last_pos = pos == 2'(OUT_DIM * OUT_DIM - 1);
  assign busy     = state != IDLE;

  assign base = 4'(pos[1]) * 4'(IMG_DIM)
              + 4'(pos[0]);

  assign bus.in_idx  = run ? base + tap_off(tap) : 4'd0;
  assign bus.f_idx   = run ? tap : 4'd0;
  assign bus.out_pos = pos;

  conv_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .load  (tap == '0),
    .a     (bus.pix),
    .b     (bus.coef),
    .sum   (sum)
  );

`ifdef CONV_SEQUENCER_RELU_EN
  assign res = sum[ACC_W-1] ? '0 : sum;
`else
  assign res = sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tap           <= '0;
      pos           <= '0;
      done          <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else if (abort && state != IDLE) begin
      state         <= IDLE;
      tap           <= '0;
      pos           <= '0;
      done          <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= mem_done ? RUN : WAIT_MEM;
            tap   <= '0;
            pos   <= '0;
          end
        end
        WAIT_MEM: begin
          if (mem_done) state <= RUN;
        end
        RUN: begin
          if (last_tap) begin
            state         <= OUT;
            tap           <= '0;
            bus.out_valid <= 1'b1;
            bus.out_data  <= res;
          end else begin
            tap <= tap + 4'd1;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (last_pos) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              pos   <= pos + 2'd1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed + randomized bench for conv_sequencer.
// Expected results come from a direct 2D convolution over tb arrays.
module tb_conv_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic mem_done;
  logic abort;
  logic busy;
  logic done;

  logic signed [7:0] img [16];
  logic signed [7:0] flt [16];

  int total = 0;
  int bad   = 0;

  conv_sequencer_if #(.DATA_W(8), .ACC_W(20)) bus ();

  assign bus.pix  = img[bus.in_idx];
  assign bus.coef = flt[bus.f_idx];

  conv_sequencer #(
    .DATA_W (8),
    .ACC_W  (20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mem_done (mem_done),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string             tag,
    input logic signed [63:0] obs,
    input logic signed [63:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int model(input int p);
    int r, c, s;
    r = p / 2;
    c = p % 2;
    s = 0;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        s += int'(img[(r + ky) * 4 + c + kx])
           * int'(flt[ky * 3 + kx]);
`ifdef CONV_SEQUENCER_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic rand_data();
    for (int i = 0; i < 16; i++) begin
      img[i] = 8'($urandom);
      flt[i] = (i < 9) ? 8'($urandom) : 8'sd0;
    end
  endtask

  // wm: cycles held in WAIT_MEM; sp/sl: stalled position and length
  task automatic run_pass(
    input int wm,
    input int sp,
    input int sl
  );
    int t, w, r, c;
    start    = 1'b1;
    mem_done = (wm == 0);
    if (wm > 0) begin
      step();
      for (int i = 0; i < wm; i++) begin
        chk("wm_busy", busy, 1);
        chk("wm_in_idx", bus.in_idx, 0);
        chk("wm_valid", bus.out_valid, 0);
        start = 1'($urandom_range(0, 1));
        step();
      end
      mem_done = 1'b1;
    end
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      r = k / 2;
      c = k % 2;
      t = 0;
      w = 0;
      if (k == sp) bus.out_ready = 1'b0;
      while (!bus.out_valid && w < 50) begin
        chk("f_idx", bus.f_idx, t);
        chk("in_idx", bus.in_idx,
            (r + t / 3) * 4 + c + t % 3);
        start = 1'($urandom_range(0, 1));
        step();
        t++;
        w++;
      end
      start = 1'b0;
      chk("run_len", w, 9);
      chk("valid", bus.out_valid, 1);
      chk("data", bus.out_data, model(k));
      chk("pos", bus.out_pos, k);
      if (k == sp) begin
        repeat (sl) begin
          step();
          chk("hold_valid", bus.out_valid, 1);
          chk("hold_data", bus.out_data, model(k));
          chk("hold_pos", bus.out_pos, k);
          chk("hold_fidx", bus.f_idx, 0);
        end
        bus.out_ready = 1'b1;
      end
      step();
      chk("done", done, (k == 3) ? 1 : 0);
      chk("busy", busy, 1);
      chk("valid_drop", bus.out_valid, 0);
    end
    step();
    chk("done_pulse", done, 0);
    chk("idle", busy, 0);
  endtask

  initial begin
    int n;
    logic seen;
    rst_n         = 1'b0;
    start         = 1'b0;
    mem_done      = 1'b0;
    abort         = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      img[i] = 8'sd0;
      flt[i] = 8'sd0;
    end
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_in_idx", bus.in_idx, 0);
    chk("rst_f_idx", bus.f_idx, 0);
    chk("rst_pos", bus.out_pos, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // identity kernel: 6,7,10,11
    for (int i = 0; i < 16; i++) begin
      img[i] = 8'(i + 1);
      flt[i] = (i == 4) ? 8'sd1 : 8'sd0;
    end
    run_pass(0, -1, 0);

    // all 127 / all 1, with a 5-cycle stall at pos 1
    for (int i = 0; i < 16; i++) begin
      img[i] = 8'sd127;
      flt[i] = (i < 9) ? 8'sd1 : 8'sd0;
    end
    run_pass(0, 1, 5);

    // most negative sum, entered via WAIT_MEM
    for (int i = 0; i < 16; i++) begin
      img[i] = -8'sd128;
      flt[i] = (i < 9) ? 8'sd127 : 8'sd0;
    end
    run_pass(3, -1, 0);

    repeat (6) begin
      rand_data();
      run_pass($urandom_range(0, 2),
               $urandom_range(0, 3),
               $urandom_range(0, 4));
    end

    // abort at pos 2 tap 4
    rand_data();
    start    = 1'b1;
    mem_done = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!(bus.out_pos == 2'd2 &&
             bus.f_idx == 4'd4) && n < 100) begin
      step();
      n++;
    end
    chk("reach_p2t4", bus.f_idx, 4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_f_idx", bus.f_idx, 0);
    seen = 1'b0;
    repeat (30) begin
      step();
      seen = seen | bus.out_valid | done;
    end
    chk("abort_quiet", seen, 0);

    // abort wins over out_ready in OUT
    start = 1'b1;
    step();
    start = 1'b0;
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      step();
      n++;
    end
    chk("abort_out_valid", bus.out_valid, 1);
    abort         = 1'b1;
    bus.out_ready = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_out_drop", bus.out_valid, 0);
    chk("abort_out_busy", busy, 0);
    chk("abort_out_done", done, 0);

    // asynchronous reset mid-pass
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_f_idx", bus.f_idx, 0);
    chk("arst_in_idx", bus.in_idx, 0);
    chk("arst_data", bus.out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (50) begin
      step();
      seen = seen | bus.out_valid | done | busy;
    end
    chk("arst_quiet", seen, 0);

    rand_data();
    run_pass(0, 3, 2);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8: signed pixel/coefficient width.
REQ-002 SHALL have parameter ACC_W, default 20: signed accumulator/result width (>= 2*DATA_W+4).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 start  in  1  request one full 2x2 convolution pass (3x3 kernel over 4x4 image).
REQ-006 mem_done  in  1  operand store holds valid image/filter.
REQ-007 abort  in  1  synchronous cancel of the current pass.
REQ-008 in_idx  out  4  image element select, 0..15, row-major.
REQ-009 f_idx  out  4  filter element select, 0..8, row-major.
REQ-010 pix  in  DATA_W  image element at in_idx, same cycle (combinational mux).
REQ-011 coef  in  DATA_W  filter element at f_idx, same cycle.
REQ-012 out_valid  out  1  out_data/out_pos valid.
REQ-013 out_ready  in  1  consumer accepts the result when out_valid=1.
REQ-014 out_data  out  ACC_W  convolution result.
REQ-015 out_pos  out  2  output position, 0..3 row-major (r*2+c).
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse after the 4th result is accepted.

Function
REQ-018 FSM states SHALL be IDLE, WAIT_MEM, RUN, OUT, FIN.
REQ-019 IDLE: start=1 and mem_done=1 -> RUN; start=1 and mem_done=0 -> WAIT_MEM; else stay.
REQ-020 WAIT_MEM: mem_done=1 -> RUN; start is ignored.
REQ-021 RUN SHALL last exactly 9 cycles per position, tap t=0..8, ky=t/3, kx=t%3.
REQ-022 In RUN: in_idx=(r+ky)*4+(c+kx), f_idx=t; outside RUN both SHALL be 0.
REQ-023 Tap 0 SHALL load acc<=pix*coef; taps 1..8 SHALL do acc<=acc+pix*coef; signed, product sign-extended to ACC_W, no saturation.
REQ-024 After tap 8 -> OUT; out_valid=1 with out_data, out_pos stable until out_ready=1.
REQ-025 OUT with out_ready=1: pos<3 -> RUN with pos+1, tap 0; pos=3 -> FIN.
REQ-026 FIN SHALL assert done for one cycle and return to IDLE.
REQ-027 Latency: start accepted at edge N (mem_done=1) -> out_valid high from cycle N+10; with out_ready held high a pass takes 40 cycles plus FIN.
REQ-028 start while busy SHALL be ignored.
REQ-029 abort=1 in any non-IDLE state SHALL return to IDLE on the next edge, clear out_valid, no done pulse; abort has priority over out_ready.
REQ-030 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, tap=0, pos=0, acc=0, out_data=0, out_valid=0, done=0, busy=0, in_idx=0, f_idx=0.
REQ-032 Reset mid-pass SHALL discard the pass; no result or done SHALL be emitted afterwards.

Configuration
REQ-033 Macro CONV_SEQUENCER_RELU_EN defined: out_data SHALL be 0 whenever the final acc is negative.
REQ-034 Macro undefined: out_data SHALL equal the raw signed acc; timing is identical in both builds.

Structure
REQ-035 Shared package SHALL hold the FSM state enum, IMG_DIM=4, K_DIM=3, OUT_DIM=2, TAPS=9.
REQ-036 One sub-module conv_mac (signed multiply-accumulate with load/accumulate control) SHALL be used; FSM and index generation stay in conv_sequencer.

Verification
REQ-037 Image 1..16, filter center=1 else 0, out_ready=1 -> outputs 6,7,10,11 at pos 0..3, done one cycle after 4th.
REQ-038 Image all 127, filter all 1 -> each out_data=1143; first out_valid exactly 10 cycles after start.
REQ-039 Image all -128, filter all 127 -> out_data=-146304; with CONV_SEQUENCER_RELU_EN -> 0.
REQ-040 out_ready low 5 cycles at pos 1 -> out_valid, out_data, out_pos held; no RUN progress; resumes on out_ready.
REQ-041 start with mem_done=0 for 3 cycles -> WAIT_MEM, busy=1, in_idx=0; RUN begins the cycle after mem_done rises.
REQ-042 abort in RUN tap 4 of pos 2, then rst_n pulse mid next pass -> IDLE, no out_valid, no done.
